// File: rtl/ntru_pkg.sv
// rtl/ntru_pkg.sv - shared types and default sizes for the ternary polynomial MAC
//
// Purpose: default ring parameters, coefficient and trit types, and the
//          sequencer state encoding.
// Ports:   none (package).
package ntru_pkg;

    localparam int DEF_N      = 701;
    localparam int DEF_LOGQ   = 13;
    localparam int DEF_ADDR_W = 10;

    typedef logic [DEF_LOGQ-1:0] coeff_t;

    // Ternary digit as stored in the r RAM: nz=0 means zero regardless of sign.
    typedef struct packed {
        logic nz;
        logic sign;
    } trit_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/ternary_term.sv
// rtl/ternary_term.sv - combinational trit * coefficient product
//
// Purpose: maps a ternary digit and an h coefficient to 0, +h or -h mod 2^LOGQ.
// Ports:
//   trit  in  2     {nz, sign}
//   h     in  LOGQ  h coefficient
//   term  out LOGQ  trit * h, wrapped to LOGQ bits
module ternary_term
    import ntru_pkg::*;
#(
    parameter int LOGQ = DEF_LOGQ
) (
    input  logic [1:0]      trit,
    input  logic [LOGQ-1:0] h,
    output logic [LOGQ-1:0] term
);

    trit_t t;

    assign t = trit;

    // Two's-complement negate as invert plus carry-in; the sign bit is the carry.
    always_comb begin
        term = '0;
        if (t.nz) begin
            term = (h ^ {LOGQ{t.sign}}) + LOGQ'(t.sign);
        end
    end

endmodule

// File: rtl/ternary_poly_mac.sv
// rtl/ternary_poly_mac.sv - coefficient-serial c = m + r*h in Z_q[x]/(x^N-1)
//
// Purpose: walks k over the output coefficients; for each one accumulates
//          m_k + sum_i r_i * h_(k-i mod N) from synchronous RAMs and presents
//          the result on a valid/ready port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a full product (accepted only when idle)
//   busy, done           run in progress / one-cycle end-of-product pulse
//   h_addr, h_rdata      h RAM port (1-cycle read latency)
//   r_addr, r_rdata      r RAM port (1-cycle read latency), trit {nz,sign}
//   m_addr, m_rdata      m RAM port (1-cycle read latency)
//   c_valid, c_ready     output handshake
//   c_data, c_idx        coefficient value and its index k
module ternary_poly_mac
    import ntru_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int LOGQ   = DEF_LOGQ,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] h_addr,
    input  logic [LOGQ-1:0]   h_rdata,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [1:0]        r_rdata,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [LOGQ-1:0]   m_rdata,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [LOGQ-1:0]   c_data,
    output logic [ADDR_W-1:0] c_idx
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] k;
    logic [LOGQ-1:0]   acc;
    logic [LOGQ-1:0]   term;
    logic [LOGQ-1:0]   acc_sum;

    // The counters are the RAM addresses, so address outputs come straight
    // from registers and freeze automatically while OUT waits for c_ready.
    assign h_addr = j;
    assign r_addr = i;
    assign m_addr = k;

    // RAM data arrives one cycle after its address, so the term consumed in
    // ACC cycle i belongs to index i-1; DRAIN consumes the last one.
    ternary_term #(.LOGQ(LOGQ)) u_term (
        .trit (r_rdata),
        .h    (h_rdata),
        .term (term)
    );

    assign acc_sum = acc + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            c_valid <= 1'b0;
            c_data  <= '0;
            c_idx   <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT;
                        busy  <= 1'b1;
                        k     <= '0;
                    end
                end
                INIT: begin
                    i     <= '0;
                    j     <= k;
                    state <= ACC;
                end
                ACC: begin
                    acc <= (i == '0) ? m_rdata : acc_sum;
                    if (i == LAST) begin
                        state <= DRAIN;
                    end else begin
                        i <= i + ADDR_W'(1);
                        // Cyclic decrement of h index avoids any modulo logic.
                        j <= (j == '0) ? LAST : j - ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    acc     <= acc_sum;
                    c_data  <= acc_sum;
                    c_idx   <= k;
                    c_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        if (k == LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            k     <= k + ADDR_W'(1);
                            state <= INIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_poly_mac.sv
// tb/tb_ternary_poly_mac.sv - directed self-checking bench for ternary_poly_mac (N=4)
module tb_ternary_poly_mac;

    localparam int N      = 4;
    localparam int LOGQ   = 13;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] h_addr;
    logic [LOGQ-1:0]   h_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [LOGQ-1:0]   m_rdata;
    logic              c_valid;
    logic              c_ready;
    logic [LOGQ-1:0]   c_data;
    logic [ADDR_W-1:0] c_idx;

    logic [LOGQ-1:0] h_mem [N];
    logic [1:0]      r_mem [N];
    logic [LOGQ-1:0] m_mem [N];
    logic [LOGQ-1:0] exp_c [N];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ternary_poly_mac #(.N(N), .LOGQ(LOGQ), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .h_addr  (h_addr),
        .h_rdata (h_rdata),
        .r_addr  (r_addr),
        .r_rdata (r_rdata),
        .m_addr  (m_addr),
        .m_rdata (m_rdata),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .c_data  (c_data),
        .c_idx   (c_idx)
    );

    // Synchronous RAM models, one cycle read latency.
    always @(posedge clk) begin
        h_rdata <= h_mem[h_addr[1:0]];
        r_rdata <= r_mem[r_addr[1:0]];
        m_rdata <= m_mem[m_addr[1:0]];
    end

    task automatic load(input logic [LOGQ-1:0] h0, h1, h2, h3,
                        input logic [1:0] r0, r1, r2, r3,
                        input logic [LOGQ-1:0] m0, m1, m2, m3,
                        input logic [LOGQ-1:0] e0, e1, e2, e3);
        h_mem[0] = h0; h_mem[1] = h1; h_mem[2] = h2; h_mem[3] = h3;
        r_mem[0] = r0; r_mem[1] = r1; r_mem[2] = r2; r_mem[3] = r3;
        m_mem[0] = m0; m_mem[1] = m1; m_mem[2] = m2; m_mem[3] = m3;
        exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3;
    endtask

    // Collects all N coefficients of one product. If started=0 it raises start
    // itself; with restart=1 it raises start again in the done cycle and returns.
    task automatic run_product(input string name, input int stall_k, input int stall_len,
                               input bit chk_lat, input bit glitch, input bit restart,
                               input bit started);
        int cnt;
        logic [LOGQ-1:0]   s_data;
        logic [ADDR_W-1:0] s_idx, s_h, s_r, s_m;
        if (!started) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int kk = 0; kk < N; kk++) begin
            cnt = 0;
            while (!c_valid && cnt < 40) begin
                @(negedge clk);
                cnt++;
                if (cnt == 1) start = 1'b0;
                if (glitch && kk == 0 && cnt == 3) start = 1'b1;
                if (glitch && kk == 0 && cnt == 4) start = 1'b0;
            end
            vectors++;
            if (c_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL %s timeout k=%0d: c_valid=%b after %0d cycles, required 1", name, kk, c_valid, cnt);
            end
            if (chk_lat && kk == 0) begin
                vectors++;
                if (cnt !== N + 3) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d cycles, required %0d", name, cnt, N + 3);
                end
            end
            vectors++;
            if (c_data !== exp_c[kk] || c_idx !== ADDR_W'(kk)) begin
                miscompares++;
                $display("FAIL %s coeff: c_data=%0d c_idx=%0d, required c_data=%0d c_idx=%0d",
                         name, c_data, c_idx, exp_c[kk], kk);
            end
            if (kk == stall_k) begin
                c_ready = 1'b0;
                s_data = c_data; s_idx = c_idx; s_h = h_addr; s_r = r_addr; s_m = m_addr;
                repeat (stall_len) begin
                    @(negedge clk);
                    vectors++;
                    if (c_valid !== 1'b1 || c_data !== s_data || c_idx !== s_idx ||
                        h_addr !== s_h || r_addr !== s_r || m_addr !== s_m) begin
                        miscompares++;
                        $display("FAIL %s stall hold: v=%b d=%0d i=%0d h=%0d r=%0d m=%0d, required v=1 d=%0d i=%0d h=%0d r=%0d m=%0d",
                                 name, c_valid, c_data, c_idx, h_addr, r_addr, m_addr,
                                 s_data, s_idx, s_h, s_r, s_m);
                    end
                end
                c_ready = 1'b1;
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done cycle: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        end
        if (restart) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s after done: done=%b busy=%b, required done=0 busy=0", name, done, busy);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || c_valid !== 1'b0 || c_data !== '0 ||
            c_idx !== '0 || h_addr !== '0 || r_addr !== '0 || m_addr !== '0) begin
            miscompares++;
            $display("FAIL %s: busy=%b done=%b v=%b d=%0d i=%0d h=%0d r=%0d m=%0d, required all 0",
                     name, busy, done, c_valid, c_data, c_idx, h_addr, r_addr, m_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; c_ready = 1'b1;
        load(1, 2, 3, 4, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2, 3, 4);
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_midrun_busy: busy=%b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async_midrun");
        @(negedge clk);
        rst_n = 1'b1;
        run_product("reset_rerun", -1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_identity();
        load(1, 2, 3, 4, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2, 3, 4);
        run_product("identity", -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_cyclic_shift();
        load(1, 2, 3, 4, 2'b00, 2'b10, 2'b00, 2'b00, 10, 10, 10, 10, 14, 11, 12, 13);
        run_product("cyclic_shift", -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_negate();
        load(1, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8191, 0, 0, 0);
        run_product("negate_wrap", -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        load(1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 8191, 0, 0, 0, 0, 0, 0, 0);
        run_product("add_wrap", -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        load(1, 2, 3, 4, 2'b01, 2'b01, 2'b01, 2'b01, 5, 6, 7, 8, 5, 6, 7, 8);
        run_product("trit_01_zero", -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        // c_k = m_k + h_k - h_(k-2)
        load(1, 2, 3, 4, 2'b10, 2'b00, 2'b11, 2'b00, 0, 1, 2, 3, 8190, 8191, 4, 5);
        run_product("backpressure", 2, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored_and_restart();
        // c_k = h_(k-3) = h_(k+1)
        load(5, 6, 7, 8, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 6, 7, 8, 5);
        run_product("start_ignored", -1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        // c_k = m_k - h_k - h_(k-1)
        load(1, 2, 3, 4, 2'b11, 2'b11, 2'b00, 2'b00, 100, 0, 0, 0, 95, 8189, 8187, 8185);
        run_product("restart_in_done", -1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_cyclic_shift();
        test_wrap_negate();
        test_backpressure();
        test_start_ignored_and_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
